gray_sched: RTL and testbench

//  Round-robin scheduler sharing one 3-bit gray step counter among NREQ requesters.
//  - Each requester asks for a burst of Len counter steps.
//  - The block clears the counter, drives its enable for exactly Len cycles, then reports the result.
//  - Sits between the requesters and the gray counter instance; it is the only driver of that counter's enable and clear.

---
 rtl/gray_sched.sv | 121 ++++++++++++
 tb/tb_gray_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sched.sv
// rtl/gray_sched.sv - round-robin burst scheduler for one shared 3-bit gray step counter
// Optional CntValue/CntOverflow sequence check is built when GRAY_SCHED_CHECK_EN is defined.
module gray_sched #(
  parameter int NREQ = 4,
  parameter int LENW = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*LENW-1:0] Len,
  output logic [NREQ-1:0]      Grant,
  output logic                 Done,
  output logic                 Wrapped,
  output logic                 Busy,
  output logic                 Err,
  output logic                 CntClr,
  output logic                 CntEn,
  input  logic [2:0]           CntValue,
  input  logic                 CntOverflow
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, sel, pick;
  logic            pick_vld;
  logic [LENW-1:0] remain, sel_len;

  assign sel_len = Len[sel*LENW +: LENW];

  // Scan downwards so the lowest offset from the pointer wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (Req[(int'(ptr) + i) % NREQ]) begin
        pick_vld = 1'b1;
        pick     = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    CntClr    = 1'b0;
    CntEn     = 1'b0;
    Done      = 1'b0;
    Busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (pick_vld) state_nxt = S_CLR;
      S_CLR: begin
        CntClr    = 1'b1;
        state_nxt = (sel_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        CntEn = 1'b1;
        if (remain == LENW'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      sel     <= '0;
      Grant   <= '0;
      Wrapped <= 1'b0;
      remain  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            sel   <= pick;
            Grant <= NREQ'(1) << pick;
          end
        end
        S_CLR:  remain <= sel_len;
        S_RUN:  remain <= remain - LENW'(1);
        S_DONE: begin
          Wrapped <= CntOverflow;
          Grant   <= '0;
          ptr     <= (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_SCHED_CHECK_EN
  logic [LENW-1:0] expect_len;
  logic [2:0]      exp_gray;
  logic            exp_ovf;

  assign exp_gray = expect_len[2:0] ^ (expect_len[2:0] >> 1);
  assign exp_ovf  = (expect_len >= LENW'(8));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      expect_len <= '0;
      Err        <= 1'b0;
    end else begin
      if (state == S_CLR) expect_len <= sel_len;
      if (state == S_DONE && (CntValue != exp_gray || CntOverflow != exp_ovf)) Err <= 1'b1;
    end
  end
`else
  logic unused_cnt_value;
  assign unused_cnt_value = ^CntValue;
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sched.sv
// tb/tb_gray_sched.sv - randomized self-checking bench for gray_sched with a behavioural gray counter
// Expects Err behaviour according to GRAY_SCHED_CHECK_EN.
module tb_gray_sched;
  localparam int NREQ = 4;
  localparam int LENW = 4;
`ifdef GRAY_SCHED_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b0;
  logic [NREQ-1:0]      Req = '0;
  logic [NREQ*LENW-1:0] Len = '0;
  logic [NREQ-1:0]      Grant;
  logic                 Done, Wrapped, Busy, Err, CntClr, CntEn;
  logic [2:0]           CntValue;
  logic                 CntOverflow;

  int tests_run = 0;
  int failed = 0;
  int ptr = 0;
  bit exp_wrapped = 1'b0;
  bit exp_err = 1'b0;
  bit force_zero = 1'b0;
  logic [2:0] cb = 3'd0;
  logic cov = 1'b0;

  gray_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Len(Len), .Grant(Grant), .Done(Done),
    .Wrapped(Wrapped), .Busy(Busy), .Err(Err), .CntClr(CntClr), .CntEn(CntEn),
    .CntValue(CntValue), .CntOverflow(CntOverflow)
  );

  always #5 Clk = ~Clk;

  // Shared gray counter: sync clear, binary count shown as gray, sticky overflow on 7->0.
  always @(posedge Clk) begin
    if (CntClr) begin
      cb  <= 3'd0;
      cov <= 1'b0;
    end else if (CntEn) begin
      cb <= cb + 3'd1;
      if (cb == 3'd7) cov <= 1'b1;
    end
  end
  assign CntValue    = force_zero ? 3'b000 : (cb ^ (cb >> 1));
  assign CntOverflow = cov;

  function automatic logic [2:0] gray3(input int n);
    logic [2:0] b;
    b = 3'(n % 8);
    return b ^ (b >> 1);
  endfunction

  function automatic int pick_winner(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++)
      if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return 0;
  endfunction

  task automatic do_burst(input logic [NREQ-1:0] r, input logic [NREQ*LENW-1:0] l,
                          input bit scramble, input string tag);
    int w, blen, gcnt, ecnt, dcnt, dat, budget;
    logic [NREQ-1:0] eg;
    bit gbad, wbad, vbad;
    Req = r;
    Len = l;
    w = pick_winner(r);
    blen = int'(l[w*LENW +: LENW]);
    eg = '0;
    eg[w] = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (Grant !== eg || CntClr !== 1'b1 || Busy !== 1'b1) begin
      failed++;
      $display("FAIL %s grant_start: Grant=%b CntClr=%b Busy=%b, expected Grant=%b CntClr=1 Busy=1",
               tag, Grant, CntClr, Busy, eg);
    end
    gcnt = 1; ecnt = 0; dcnt = 0; dat = 0; budget = 0;
    gbad = 1'b0; wbad = 1'b0; vbad = 1'b0;
    while (budget < 40) begin
      budget++;
      @(negedge Clk);
      if (Grant == '0) break;
      gcnt++;
      if (Grant !== eg) gbad = 1'b1;
      if (CntEn === 1'b1) ecnt++;
      if (Done === 1'b1) begin
        dcnt++;
        dat = gcnt;
        if (!force_zero && CntValue !== gray3(blen)) vbad = 1'b1;
      end else if (dcnt == 0 && Wrapped !== exp_wrapped) wbad = 1'b1;
      if (scramble) begin
        Req = NREQ'($urandom);
        Len = (NREQ*LENW)'($urandom);
      end
    end
    exp_wrapped = (blen >= 8);
    if (CHK && force_zero && gray3(blen) != 3'b000) exp_err = 1'b1;
    tests_run++;
    if (gcnt != blen + 2) begin
      failed++;
      $display("FAIL %s grant_cycles: got %0d, expected %0d", tag, gcnt, blen + 2);
    end
    tests_run++;
    if (ecnt != blen) begin
      failed++;
      $display("FAIL %s en_cycles: got %0d, expected %0d", tag, ecnt, blen);
    end
    tests_run++;
    if (dcnt != 1 || dat != blen + 2) begin
      failed++;
      $display("FAIL %s done_pulse: count %0d at grant cycle %0d, expected 1 at %0d", tag, dcnt, dat, blen + 2);
    end
    tests_run++;
    if (gbad || wbad || vbad) begin
      failed++;
      $display("FAIL %s burst_hold: grant_unstable=%0d wrapped_changed=%0d cnt_value_bad=%0d, expected all 0",
               tag, gbad, wbad, vbad);
    end
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Grant !== '0) begin
      failed++;
      $display("FAIL %s idle_after: Busy=%b Done=%b Grant=%b, expected 0 0 0", tag, Busy, Done, Grant);
    end
    tests_run++;
    if (Wrapped !== exp_wrapped || Err !== exp_err) begin
      failed++;
      $display("FAIL %s flags: Wrapped=%b Err=%b, expected Wrapped=%b Err=%b", tag, Wrapped, Err, exp_wrapped, exp_err);
    end
    ptr = (w + 1) % NREQ;
    Req = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Req = 4'hF;
    Len = 16'h3333;
    repeat (3) @(negedge Clk);
    tests_run++;
    if ({Grant, Done, Wrapped, Busy, Err, CntClr, CntEn} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: Grant=%b Done=%b Wrapped=%b Busy=%b Err=%b CntClr=%b CntEn=%b, expected all 0",
               Grant, Done, Wrapped, Busy, Err, CntClr, CntEn);
    end
    Req = '0;
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    do_burst(4'b0001, 16'h0003, 1'b0, "len3");
  endtask

  task automatic test_zero_len();
    do_burst(4'b0100, 16'h5055, 1'b0, "len0");
  endtask

  task automatic test_wrap();
    do_burst(4'b0001, 16'h0008, 1'b0, "len8");
    do_burst(4'b0010, 16'h00F0, 1'b0, "len15");
  endtask

  task automatic test_mid_reset();
    bit bad;
    Req = 4'b0100;
    Len = 16'h0A00;
    repeat (3) @(negedge Clk);
    tests_run++;
    if (Busy !== 1'b1 || CntEn !== 1'b1 || Grant !== 4'b0100) begin
      failed++;
      $display("FAIL mid_reset_run: Busy=%b CntEn=%b Grant=%b, expected 1 1 0100", Busy, CntEn, Grant);
    end
    Reset = 1'b0;
    #1;
    tests_run++;
    if ({Grant, Done, Wrapped, Busy, Err, CntClr, CntEn} !== '0) begin
      failed++;
      $display("FAIL mid_reset_now: Grant=%b Done=%b Wrapped=%b Busy=%b Err=%b, expected all 0",
               Grant, Done, Wrapped, Busy, Err);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if ({Grant, Done, Busy, CntClr, CntEn} !== '0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      failed++;
      $display("FAIL mid_reset_hold: outputs became nonzero during reset, expected 0");
    end
    Reset = 1'b1;
    Req = '0;
    ptr = 0;
    exp_wrapped = 1'b0;
    exp_err = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) do_burst(4'hF, 16'h1111, 1'b0, "rr");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++)
      do_burst(NREQ'($urandom_range(1, 15)), (NREQ*LENW)'($urandom), 1'b1, "rand");
  endtask

  task automatic test_err_check();
    force_zero = 1'b1;
    do_burst(4'b0001, 16'h0002, 1'b0, "err_forced");
    force_zero = 1'b0;
    do_burst(4'b0010, 16'h0030, 1'b0, "err_held");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_mid_reset();
    test_round_robin();
    test_random();
    test_err_check();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
